// File: rtl/ddr5_cmd_scheduler.sv
// In-order closed-page DDR5 command scheduler: a request FIFO feeding an FSM that issues
// ACT0/ACT1/RD|WR(0,1)/PRE per request under fixed timing, with periodic refresh.
module ddr5_cmd_scheduler #(
  parameter int QDEPTH       = 16,
  parameter int T_RCD        = 39,
  parameter int T_RAS        = 76,
  parameter int T_RD2PRE     = 18,
  parameter int T_WR2PRE     = 76,
  parameter int T_RP         = 39,
  parameter int T_RFC        = 708,
  parameter int REF_INTERVAL = 9360
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [33:0] req_addr,
  input  logic [1:0]  req_op,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_addr,
  output logic        cmd_is_col,
  output logic [4:0]  q_count,
  output logic        busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int RW = $clog2(REF_INTERVAL);

  // Precharge distance measured from COL0: the later of the tRAS and tRTP/write-recovery limits.
  localparam int RAS_AFTER_COL = T_RAS - T_RCD;
  localparam int RD_GAP = (RAS_AFTER_COL > T_RD2PRE) ? RAS_AFTER_COL : T_RD2PRE;
  localparam int WR_GAP = (RAS_AFTER_COL > T_WR2PRE) ? RAS_AFTER_COL : T_WR2PRE;

  localparam logic [15:0] LD_RCD    = 16'(T_RCD - 3);
  localparam logic [15:0] LD_PRE_RD = 16'(RD_GAP - 3);
  localparam logic [15:0] LD_PRE_WR = 16'(WR_GAP - 3);
  localparam logic [15:0] LD_RP     = 16'(T_RP - 2);
  localparam logic [15:0] LD_RFC    = 16'(T_RFC - 2);

  localparam logic [2:0] CMD_ACT0 = 3'd0;
  localparam logic [2:0] CMD_ACT1 = 3'd1;
  localparam logic [2:0] CMD_RD0  = 3'd2;
  localparam logic [2:0] CMD_RD1  = 3'd3;
  localparam logic [2:0] CMD_WR0  = 3'd4;
  localparam logic [2:0] CMD_WR1  = 3'd5;
  localparam logic [2:0] CMD_PRE  = 3'd6;
  localparam logic [2:0] CMD_REF  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT0,
    S_ACT1,
    S_WAIT_RCD,
    S_COL0,
    S_COL1,
    S_WAIT_PRE,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC
  } state_t;

  state_t state;
  logic [15:0] timer;

  logic [31:0]   fifo_mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  logic [RW-1:0] ref_cnt;
  logic          ref_wrap;
  logic          ref_pending;

  logic [15:0] cur_row;
  logic [7:0]  cur_col;
  logic [2:0]  cur_bg;
  logic [1:0]  cur_bank;
  logic        cur_ch;
  logic        cur_wr;

  logic [31:0] head;
  logic [1:0]  head_op;
  logic [15:0] head_row;
  logic [7:0]  head_col;
  logic [1:0]  head_bank;
  logic [2:0]  head_bg;
  logic        head_ch;

  // Only col_low[5:4] reaches the column address; the burst-offset bits are dropped.
  logic unused_col_low;
  assign unused_col_low = ^req_addr[3:0];

  assign req_ready = (count < (AW+1)'(QDEPTH));
  assign q_count   = 5'(count);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !ref_pending && (count != '0);

  assign head      = fifo_mem[rd_ptr];
  assign head_op   = head[31:30];
  assign head_row  = head[29:14];
  assign head_col  = head[13:6];
  assign head_bank = head[5:4];
  assign head_bg   = head[3:1];
  assign head_ch   = head[0];

  // FIFO entries hold the request already split into its DRAM coordinates.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_op, req_addr[33:18], req_addr[17:12], req_addr[5:4],
                           req_addr[11:10], req_addr[9:7], req_addr[6]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ref_wrap = (ref_cnt == RW'(REF_INTERVAL - 1));

  // A refresh request is a single sticky flag, so back-to-back wraps never queue two REFs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_wrap) ref_cnt <= '0;
      else          ref_cnt <= ref_cnt + 1'b1;
      if (ref_wrap)              ref_pending <= 1'b1;
      else if (state == S_REF)   ref_pending <= 1'b0;
    end
  end

  // Command outputs are registered alongside the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      cur_bg      <= '0;
      cur_bank    <= '0;
      cur_ch      <= 1'b0;
      cur_wr      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd         <= CMD_ACT0;
      cmd_channel <= 1'b0;
      cmd_bg      <= '0;
      cmd_bank    <= '0;
      cmd_addr    <= '0;
      cmd_is_col  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      cmd         <= CMD_ACT0;
      cmd_channel <= 1'b0;
      cmd_bg      <= '0;
      cmd_bank    <= '0;
      cmd_addr    <= '0;
      cmd_is_col  <= 1'b0;
      busy        <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ref_pending) begin
            state     <= S_REF;
            cmd_valid <= 1'b1;
            cmd       <= CMD_REF;
          end else if (count != '0) begin
            state       <= S_ACT0;
            cur_row     <= head_row;
            cur_col     <= head_col;
            cur_bg      <= head_bg;
            cur_bank    <= head_bank;
            cur_ch      <= head_ch;
            cur_wr      <= (head_op == 2'd1);
            cmd_valid   <= 1'b1;
            cmd         <= CMD_ACT0;
            cmd_channel <= head_ch;
            cmd_bg      <= head_bg;
            cmd_bank    <= head_bank;
            cmd_addr    <= head_row;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ACT0: begin
          state       <= S_ACT1;
          cmd_valid   <= 1'b1;
          cmd         <= CMD_ACT1;
          cmd_channel <= cur_ch;
          cmd_bg      <= cur_bg;
          cmd_bank    <= cur_bank;
          cmd_addr    <= cur_row;
        end
        S_ACT1: begin
          state <= S_WAIT_RCD;
          timer <= LD_RCD;
        end
        S_WAIT_RCD: begin
          if (timer == '0) begin
            state       <= S_COL0;
            cmd_valid   <= 1'b1;
            cmd         <= cur_wr ? CMD_WR0 : CMD_RD0;
            cmd_channel <= cur_ch;
            cmd_bg      <= cur_bg;
            cmd_bank    <= cur_bank;
            cmd_addr    <= {8'h00, cur_col};
            cmd_is_col  <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COL0: begin
          state       <= S_COL1;
          cmd_valid   <= 1'b1;
          cmd         <= cur_wr ? CMD_WR1 : CMD_RD1;
          cmd_channel <= cur_ch;
          cmd_bg      <= cur_bg;
          cmd_bank    <= cur_bank;
          cmd_addr    <= {8'h00, cur_col};
          cmd_is_col  <= 1'b1;
        end
        S_COL1: begin
          state <= S_WAIT_PRE;
          timer <= cur_wr ? LD_PRE_WR : LD_PRE_RD;
        end
        S_WAIT_PRE: begin
          if (timer == '0) begin
            state       <= S_PRE;
            cmd_valid   <= 1'b1;
            cmd         <= CMD_PRE;
            cmd_channel <= cur_ch;
            cmd_bg      <= cur_bg;
            cmd_bank    <= cur_bank;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_PRE: begin
          state <= S_WAIT_RP;
          timer <= LD_RP;
        end
        S_WAIT_RP: begin
          if (timer == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_REF: begin
          state <= S_WAIT_RFC;
          timer <= LD_RFC;
        end
        S_WAIT_RFC: begin
          if (timer == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Directed bench for ddr5_cmd_scheduler: a negedge monitor logs every issued command with
// its cycle (relative to reset release) and each scenario task checks that log.
module tb_ddr5_cmd_scheduler;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [33:0] req_addr;
  logic [1:0]  req_op;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic        cmd_is_col;
  logic [4:0]  q_count;
  logic        busy;

  int checks;
  int failures;
  int cyc;
  int t0;

  localparam int LOGN = 512;
  int          log_cyc  [LOGN];
  logic [2:0]  log_cmd  [LOGN];
  logic [15:0] log_addr [LOGN];
  logic [2:0]  log_bg   [LOGN];
  logic [1:0]  log_bank [LOGN];
  logic        log_ch   [LOGN];
  logic        log_col  [LOGN];
  int          log_n;

  ddr5_cmd_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_op      (req_op),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_channel (cmd_channel),
    .cmd_bg      (cmd_bg),
    .cmd_bank    (cmd_bank),
    .cmd_addr    (cmd_addr),
    .cmd_is_col  (cmd_is_col),
    .q_count     (q_count),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n && cmd_valid && log_n < LOGN) begin
      log_cyc[log_n]  <= cyc - t0;
      log_cmd[log_n]  <= cmd;
      log_addr[log_n] <= cmd_addr;
      log_bg[log_n]   <= cmd_bg;
      log_bank[log_n] <= cmd_bank;
      log_ch[log_n]   <= cmd_channel;
      log_col[log_n]  <= cmd_is_col;
      log_n           <= log_n + 1;
    end
  end

  function automatic logic [33:0] mk_addr(input logic [15:0] row, input logic [5:0] colh,
                                          input logic [1:0] bank, input logic [2:0] bg,
                                          input logic ch, input logic [5:0] coll);
    return {row, colh, bank, bg, ch, coll};
  endfunction

  task automatic wait_cycle(input int rel);
    while ((cyc - t0) < rel) @(negedge clock);
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (q_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_q_count: got %0d expected 0", q_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({cmd, cmd_addr, cmd_bg, cmd_bank, cmd_channel, cmd_is_col} !== 26'd0) begin
      failures++; $display("[TB] FAIL reset_cmd_fields: got %h expected 0", {cmd, cmd_addr, cmd_bg, cmd_bank, cmd_channel, cmd_is_col});
    end
  endtask

  task automatic test_single_read();
    int          base;
    int          exp_cyc [5];
    logic [2:0]  exp_cmd [5];
    logic [15:0] exp_addr[5];
    logic        exp_col [5];
    exp_cyc  = '{2, 3, 41, 42, 78};
    exp_cmd  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    exp_addr = '{16'h1A2B, 16'h1A2B, 16'h0057, 16'h0057, 16'h0000};
    exp_col  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    base = log_n;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_ready: got %b expected 1", req_ready); end
    req_valid = 1'b1;
    req_addr  = mk_addr(16'h1A2B, 6'h15, 2'd2, 3'd5, 1'b1, 6'h30);
    req_op    = 2'd0;
    @(negedge clock);
    req_valid = 1'b0;
    wait_cycle(116);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rd_busy_116: got %b expected 1", busy); end
    wait_cycle(117);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rd_busy_117: got %b expected 0", busy); end
    wait_cycle(120);
    checks++; if (log_n - base !== 5) begin failures++; $display("[TB] FAIL rd_cmd_count: got %0d expected 5", log_n - base); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (log_cyc[base+i] !== exp_cyc[i]) begin failures++; $display("[TB] FAIL rd_cycle[%0d]: got %0d expected %0d", i, log_cyc[base+i], exp_cyc[i]); end
      checks++; if (log_cmd[base+i] !== exp_cmd[i]) begin failures++; $display("[TB] FAIL rd_cmd[%0d]: got %0d expected %0d", i, log_cmd[base+i], exp_cmd[i]); end
      checks++; if (log_addr[base+i] !== exp_addr[i]) begin failures++; $display("[TB] FAIL rd_addr[%0d]: got %h expected %h", i, log_addr[base+i], exp_addr[i]); end
      checks++; if ({log_bg[base+i], log_bank[base+i], log_ch[base+i], log_col[base+i]} !== {3'd5, 2'd2, 1'b1, exp_col[i]}) begin
        failures++; $display("[TB] FAIL rd_bg_bank_ch_col[%0d]: got %b expected %b", i,
          {log_bg[base+i], log_bank[base+i], log_ch[base+i], log_col[base+i]}, {3'd5, 2'd2, 1'b1, exp_col[i]});
      end
    end
  endtask

  task automatic test_write();
    int          base;
    int          exp_cyc [6];
    logic [2:0]  exp_cmd [6];
    logic [15:0] exp_addr[6];
    exp_cyc  = '{2, 3, 41, 42, 117, 157};
    exp_cmd  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd0};
    exp_addr = '{16'h1A2B, 16'h1A2B, 16'h0057, 16'h0057, 16'h0000, 16'h2C3D};
    apply_reset();
    base = log_n;
    req_valid = 1'b1;
    req_addr  = mk_addr(16'h1A2B, 6'h15, 2'd2, 3'd5, 1'b1, 6'h30);
    req_op    = 2'd1;
    @(negedge clock);
    req_addr  = mk_addr(16'h2C3D, 6'h15, 2'd2, 3'd5, 1'b1, 6'h30);
    req_op    = 2'd0;
    @(negedge clock);
    req_valid = 1'b0;
    wait_cycle(160);
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_cyc[base+i] !== exp_cyc[i]) begin failures++; $display("[TB] FAIL wr_cycle[%0d]: got %0d expected %0d", i, log_cyc[base+i], exp_cyc[i]); end
      checks++; if (log_cmd[base+i] !== exp_cmd[i]) begin failures++; $display("[TB] FAIL wr_cmd[%0d]: got %0d expected %0d", i, log_cmd[base+i], exp_cmd[i]); end
      checks++; if (log_addr[base+i] !== exp_addr[i]) begin failures++; $display("[TB] FAIL wr_addr[%0d]: got %h expected %h", i, log_addr[base+i], exp_addr[i]); end
    end
  endtask

  // 17 reads (ops 0, 2 and 3 rotating) pushed on consecutive cycles, then a push held
  // against a full FIFO through the pop at cycle 117.
  task automatic test_back_to_back();
    int base;
    int k;
    int wr_seen;
    apply_reset();
    base = log_n;
    for (int i = 0; i < 17; i++) begin
      checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
      req_valid = 1'b1;
      req_addr  = mk_addr(16'(16'h0100 + i), 6'(i), 2'(i), 3'(i), 1'(i), 6'h00);
      req_op    = (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd2 : 2'd3);
      @(negedge clock);
    end
    req_addr = mk_addr(16'hDEAD, 6'h00, 2'd0, 3'd0, 1'b0, 6'h00);
    req_op   = 2'd0;
    checks++; if (q_count !== 5'd16) begin failures++; $display("[TB] FAIL b2b_full_count: got %0d expected 16", q_count); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_full_ready: got %b expected 0", req_ready); end
    wait_cycle(117);
    checks++; if (q_count !== 5'd16) begin failures++; $display("[TB] FAIL b2b_count_117: got %0d expected 16", q_count); end
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (q_count !== 5'd15) begin failures++; $display("[TB] FAIL b2b_pushpop_count: got %0d expected 15", q_count); end
    wait_cycle(2000);
    k = 0;
    wr_seen = 0;
    for (int j = base; j < log_n; j++) begin
      if (log_cmd[j] == 3'd4 || log_cmd[j] == 3'd5) wr_seen++;
      if (log_cmd[j] == 3'd0) begin
        if (k < 17) begin
          checks++; if (log_addr[j] !== 16'(16'h0100 + k)) begin failures++; $display("[TB] FAIL b2b_act_row[%0d]: got %h expected %h", k, log_addr[j], 16'(16'h0100 + k)); end
          checks++; if (log_cyc[j] !== 2 + 116 * k) begin failures++; $display("[TB] FAIL b2b_act_cycle[%0d]: got %0d expected %0d", k, log_cyc[j], 2 + 116 * k); end
        end
        k++;
      end
    end
    checks++; if (k !== 17) begin failures++; $display("[TB] FAIL b2b_act_count: got %0d expected 17", k); end
    checks++; if (wr_seen !== 0) begin failures++; $display("[TB] FAIL b2b_write_cmds: got %0d expected 0", wr_seen); end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = mk_addr(16'(16'h0300 + i), 6'h01, 2'd1, 3'd1, 1'b0, 6'h00);
      req_op    = 2'd0;
      @(negedge clock);
    end
    req_valid = 1'b0;
    wait_cycle(20);
    checks++; if (q_count !== 5'd2) begin failures++; $display("[TB] FAIL mid_count_before: got %0d expected 2", q_count); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (q_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_q_count: got %0d expected 0", q_count); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_req_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    base = log_n;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    t0 = cyc;
    wait_cycle(200);
    checks++; if (log_n !== base) begin failures++; $display("[TB] FAIL mid_idle_cmds: got %0d expected 0", log_n - base); end
    req_valid = 1'b1;
    req_addr  = mk_addr(16'h0777, 6'h01, 2'd1, 3'd1, 1'b0, 6'h00);
    req_op    = 2'd0;
    @(negedge clock);
    req_valid = 1'b0;
    wait_cycle(205);
    checks++; if (log_cmd[base] !== 3'd0 || log_addr[base] !== 16'h0777) begin
      failures++; $display("[TB] FAIL mid_new_act: got cmd %0d row %h expected cmd 0 row 0777", log_cmd[base], log_addr[base]);
    end
    checks++; if (log_cyc[base] !== 202) begin failures++; $display("[TB] FAIL mid_new_act_cycle: got %0d expected 202", log_cyc[base]); end
  endtask

  task automatic test_refresh();
    int          base;
    int          exp_cyc [7];
    logic [2:0]  exp_cmd [7];
    logic [15:0] exp_addr[7];
    exp_cyc  = '{9302, 9303, 9341, 9342, 9378, 9418, 10127};
    exp_cmd  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0};
    exp_addr = '{16'h0AAA, 16'h0AAA, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0BBB};
    apply_reset();
    base = log_n;
    wait_cycle(9300);
    req_valid = 1'b1;
    req_addr  = mk_addr(16'h0AAA, 6'h01, 2'd1, 3'd3, 1'b0, 6'h10);
    req_op    = 2'd0;
    @(negedge clock);
    req_addr  = mk_addr(16'h0BBB, 6'h02, 2'd0, 3'd6, 1'b1, 6'h20);
    @(negedge clock);
    req_valid = 1'b0;
    wait_cycle(10135);
    for (int i = 0; i < 7; i++) begin
      checks++; if (log_cyc[base+i] !== exp_cyc[i]) begin failures++; $display("[TB] FAIL ref_cycle[%0d]: got %0d expected %0d", i, log_cyc[base+i], exp_cyc[i]); end
      checks++; if (log_cmd[base+i] !== exp_cmd[i]) begin failures++; $display("[TB] FAIL ref_cmd[%0d]: got %0d expected %0d", i, log_cmd[base+i], exp_cmd[i]); end
      checks++; if (log_addr[base+i] !== exp_addr[i]) begin failures++; $display("[TB] FAIL ref_addr[%0d]: got %h expected %h", i, log_addr[base+i], exp_addr[i]); end
    end
    checks++; if ({log_bg[base+4], log_bank[base+4]} !== {3'd3, 2'd1}) begin
      failures++; $display("[TB] FAIL ref_pre_bg_bank: got %b expected %b", {log_bg[base+4], log_bank[base+4]}, {3'd3, 2'd1});
    end
    checks++; if ({log_bg[base+5], log_bank[base+5], log_col[base+5]} !== 6'd0) begin
      failures++; $display("[TB] FAIL ref_ref_fields: got %b expected 0", {log_bg[base+5], log_bank[base+5], log_col[base+5]});
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    t0        = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_op    = 2'd0;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
